modulo_input_handshake: RTL
===========================

# modulo_input_handshake

Switch-input stage for the `IN` instruction, upstream of the output module. When the CPU requests input, the block stalls the CPU and waits for the user to confirm with a debounced push-button. It then captures SW[12:0] into a 32-bit word and releases the CPU with a one-cycle valid pulse. The captured word drives the CPU write-back path, and from there the output module's `valor_saida`/`enable_in` LED path.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable `clk` cycles required to accept a key level change (20 ms at 50 MHz); legal range ≥ 2.
- `clk` input 1: 50 MHz board clock; the only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_in` input 1: CPU executing `IN`; level held until `in_valid` is seen, synchronous to `clk`.
- `switch_enable` input 1: SW[13]; 1 = switches enabled for input.
- `switches` input 13: SW[12:0] raw data.
- `key_confirm_n` input 1: raw confirm push-button, active-low, asynchronous and bouncy.
- `valor_entrada` output 32: captured input word.
- `in_valid` output 1: one-cycle pulse, `valor_entrada` is valid.
- `stall_cpu` output 1: holds CPU PC/register writes while waiting.
- `waiting` output 1: LED indicator, high while awaiting the confirm press.

## Operation
- Key path: a 2-flop synchronizer produces `key_s`. The debouncer holds `key_db` (reset 1) and a counter (reset 0).
  - If `key_s == key_db`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` with `key_s` still different, `key_db <= key_s` and the counter clears.
  - Press event = `key_db` 1→0 transition (one cycle, from a registered copy of `key_db`).
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: if `req_in & switch_enable` → WAIT_PRESS. If `req_in & ~switch_enable` → capture 0 and go to DONE (no wait).
  - WAIT_PRESS: on a press event, capture `switches` → WAIT_RELEASE. A key already held on entry produces no event; the user must release and press again.
  - WAIT_RELEASE: when `key_db` == 1 → DONE.
  - DONE: stays until `req_in` == 0, then → IDLE. No retrigger while `req_in` stays high.
- Outputs:
  - `stall_cpu` = 1 in WAIT_PRESS and WAIT_RELEASE, and in IDLE when `req_in` is high (combinational, so the CPU stalls in the request cycle). It is 0 in DONE.
  - `waiting` = 1 only in WAIT_PRESS.
  - `in_valid` = 1 exactly on the first cycle in DONE.
- Width rule: `valor_entrada = {19'b0, switches}` captured on the press event. It holds its value until the next capture.
- `switch_enable` falling while in WAIT_PRESS/WAIT_RELEASE does not abort the transaction.
- Reset, including mid-transaction:
  - State → IDLE, counter → 0, `key_db` → 1, synchronizer flops → 1.
  - `valor_entrada` = 0, `in_valid` = 0, `stall_cpu` = 0 (unless `req_in` is high), `waiting` = 0.

## Timing
- Raw key sampled low first at edge 0:
  - `key_s` low after edge 1.
  - `key_db` falls at edge `DEBOUNCE_CYCLES+1`.
  - `valor_entrada` updated and state = WAIT_RELEASE at edge `DEBOUNCE_CYCLES+2`.
- Release is symmetric. DONE is entered at the edge after `key_db` returns to 1, and `in_valid` is high for the following cycle.
- Disabled path (`switch_enable` = 0): `req_in` high before edge 0 → DONE and `valor_entrada` = 0 at edge 0, `in_valid` during cycle 1.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles never changes `key_db`.

## Configuration
- `INPUT_SIGN_EXTEND_EN` defined: `valor_entrada = {{19{switches[12]}}, switches}`, so negative values can be entered in two's complement.
- Undefined: zero-extension as above. The FSM and timing are identical either way.

## Test plan
- `DEBOUNCE_CYCLES`=4, `switch_enable`=1, `switches`=13'd1234, `req_in` raised → `stall_cpu`=1, `waiting`=1. Clean key press → `valor_entrada`=1234 at edge 6 after first low sample. Release → one `in_valid` pulse, `stall_cpu`=0.
- Key bounce pattern low/high every 2 cycles for 20 cycles in WAIT_PRESS → no capture, state stays WAIT_PRESS.
- Key held low when `req_in` rises → no capture until release plus new press; `switches` changed to 13'd77 before the second press → `valor_entrada`=77.
- `switch_enable`=0, `req_in` pulse → `valor_entrada`=0, `in_valid` one cycle later, `waiting` never 1. With `req_in` held for 10 cycles → exactly one `in_valid`.
- `reset_n` low during WAIT_RELEASE → all outputs at reset values immediately (`stall_cpu` = `req_in`). After release with `req_in`=1, the FSM restarts in WAIT_PRESS.
- `INPUT_SIGN_EXTEND_EN` defined, `switches`=13'h1FFF → `valor_entrada`=32'hFFFFFFFF. Undefined → 32'h00001FFF.

Source files
------------

// File: rtl/modulo_input_handshake.sv
// rtl/modulo_input_handshake.sv - IN-instruction switch capture gated by a debounced confirm key
// Optional feature macro: INPUT_SIGN_EXTEND_EN (sign-extend SW[12:0] instead of zero-extend).
module modulo_input_handshake #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_in,
  input  logic        switch_enable,
  input  logic [12:0] switches,
  input  logic        key_confirm_n,
  output logic [31:0] valor_entrada,
  output logic        in_valid,
  output logic        stall_cpu,
  output logic        waiting
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             key_meta;
  logic             key_s;
  logic             key_db;
  logic             key_db_q;
  logic [CNT_W-1:0] db_cnt;
  logic             press_evt;
  logic             capture_sw;
  logic             capture_zero;
  logic [31:0]      switch_word;

`ifdef INPUT_SIGN_EXTEND_EN
  assign switch_word = {{19{switches[12]}}, switches};
`else
  assign switch_word = {19'b0, switches};
`endif

  // A press is the debounced key falling; held-down keys never re-fire.
  assign press_evt = key_db_q & ~key_db;

  // Two-flop synchronizer for the raw, asynchronous push-button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_confirm_n;
      key_s    <= key_meta;
    end
  end

  // Accept a new key level only after it differs for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_db_q <= key_db;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  // State register, captured word, and the single-cycle valid on DONE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      valor_entrada <= '0;
      in_valid      <= 1'b0;
    end else begin
      state    <= state_next;
      in_valid <= (state_next == S_DONE) && (state != S_DONE);
      if (capture_zero) begin
        valor_entrada <= '0;
      end else if (capture_sw) begin
        valor_entrada <= switch_word;
      end
    end
  end

  // Next-state and stall/indicator decode; stall follows req_in combinationally in IDLE.
  always_comb begin
    state_next   = state;
    stall_cpu    = 1'b0;
    waiting      = 1'b0;
    capture_sw   = 1'b0;
    capture_zero = 1'b0;
    case (state)
      S_IDLE: begin
        stall_cpu = req_in;
        if (req_in) begin
          if (switch_enable) begin
            state_next = S_WAIT_PRESS;
          end else begin
            capture_zero = 1'b1;
            state_next   = S_DONE;
          end
        end
      end
      S_WAIT_PRESS: begin
        stall_cpu = 1'b1;
        waiting   = 1'b1;
        if (press_evt) begin
          capture_sw = 1'b1;
          state_next = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        stall_cpu = 1'b1;
        if (key_db) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!req_in) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
